// File: rtl/ahb_default_slave_p.sv
// AHB-Lite default slave: answers unclaimed transfers with a two-cycle
// ERROR after optional wait states and logs the most recent fault.
module ahb_default_slave_p #(
  parameter int NUM_SLAVES  = 5,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0,
  parameter int CNT_W       = 8
) (
  input  logic                  h_clk,
  input  logic                  h_reset,
  input  logic [NUM_SLAVES-1:0] h_sel,
  input  logic [1:0]            h_trans,
  input  logic [ADDR_W-1:0]     h_addr,
  input  logic                  h_write,
  input  logic                  h_ready,
  output logic                  h_ready_out,
  output logic                  h_resp,
  input  logic                  err_clr,
  output logic                  err_valid,
  output logic [ADDR_W-1:0]     err_addr,
  output logic                  err_write,
  output logic [CNT_W-1:0]      err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  localparam logic [3:0] WS_LOAD =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       acc;

  assign acc = h_ready && (h_sel == '0) &&
               (h_trans == 2'b10 || h_trans == 2'b11);

  always_ff @(posedge h_clk) begin
    if (h_reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_IDLE, S_ERR2: begin
        state_nxt = S_IDLE;
        if (acc) begin
          if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS_LOAD;
          end else begin
            state_nxt = S_ERR1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_ERR1;
        else           cnt_nxt   = cnt - 4'd1;
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign h_ready_out = (state == S_IDLE) || (state == S_ERR2);
  assign h_resp      = (state == S_ERR1) || (state == S_ERR2);

  // An accept in the same cycle as a clear restarts the log at one.
  always_ff @(posedge h_clk) begin
    if (h_reset) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_write <= 1'b0;
      err_count <= '0;
    end else if (acc) begin
      err_valid <= 1'b1;
      err_addr  <= h_addr;
      err_write <= h_write;
      if (err_clr)                err_count <= CNT_W'(1);
      else if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_count <= '0;
    end
  end

endmodule

// File: tb/tb_ahb_default_slave_p.sv
// Bench for ahb_default_slave_p: three instances (0 waits, 3 waits,
// 2-bit counter), each looping its HREADYOUT back as bus HREADY.
module tb_ahb_default_slave_p;

  typedef struct {
    logic        rdy;
    logic        resp;
    logic        valid;
    logic [7:0]  count;
    logic [31:0] addr;
    logic        wr;
  } obs_t;

  typedef struct {
    logic        rst;
    logic        clr;
    logic [4:0]  sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    obs_t        exp;
  } vec_t;

  logic        h_clk = 1'b0;
  logic        h_reset = 1'b1;
  logic        err_clr = 1'b0;
  logic        h_write = 1'b0;
  logic [4:0]  h_sel = '0;
  logic [1:0]  h_trans = '0;
  logic [31:0] h_addr = '0;

  always #5 h_clk = ~h_clk;

  logic r0, p0, v0, w0;
  logic r1, p1, v1, w1;
  logic r2, p2, v2, w2;
  logic [31:0] a0, a1, a2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  ahb_default_slave_p #(.WAIT_STATES(0)) u0 (
    .h_clk(h_clk), .h_reset(h_reset), .h_sel(h_sel),
    .h_trans(h_trans), .h_addr(h_addr), .h_write(h_write),
    .h_ready(r0), .h_ready_out(r0), .h_resp(p0),
    .err_clr(err_clr), .err_valid(v0), .err_addr(a0),
    .err_write(w0), .err_count(c0)
  );

  ahb_default_slave_p #(.WAIT_STATES(3)) u3 (
    .h_clk(h_clk), .h_reset(h_reset), .h_sel(h_sel),
    .h_trans(h_trans), .h_addr(h_addr), .h_write(h_write),
    .h_ready(r1), .h_ready_out(r1), .h_resp(p1),
    .err_clr(err_clr), .err_valid(v1), .err_addr(a1),
    .err_write(w1), .err_count(c1)
  );

  ahb_default_slave_p #(.WAIT_STATES(0), .CNT_W(2)) uc (
    .h_clk(h_clk), .h_reset(h_reset), .h_sel(h_sel),
    .h_trans(h_trans), .h_addr(h_addr), .h_write(h_write),
    .h_ready(r2), .h_ready_out(r2), .h_resp(p2),
    .err_clr(err_clr), .err_valid(v2), .err_addr(a2),
    .err_write(w2), .err_count(c2)
  );

  int   total = 0;
  int   bad = 0;
  obs_t exp_q[$];
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic obs_t mk(input logic rdy, input logic resp,
                              input logic valid, input logic [7:0] cnt,
                              input logic [31:0] addr, input logic wr);
    obs_t o;
    o.rdy = rdy; o.resp = resp; o.valid = valid;
    o.count = cnt; o.addr = addr; o.wr = wr;
    return o;
  endfunction

  function automatic vec_t mkv(input logic rst, input logic clr,
                               input logic [4:0] sel,
                               input logic [1:0] trans,
                               input logic [31:0] addr, input logic wr,
                               input obs_t exp);
    vec_t v;
    v.rst = rst; v.clr = clr; v.sel = sel; v.trans = trans;
    v.addr = addr; v.wr = wr; v.exp = exp;
    return v;
  endfunction

  function automatic obs_t actual(input int inst);
    case (inst)
      0:       return mk(r0, p0, v0, c0, a0, w0);
      1:       return mk(r1, p1, v1, c1, a1, w1);
      default: return mk(r2, p2, v2, {6'b0, c2}, a2, w2);
    endcase
  endfunction

  task automatic step(input int inst, input logic rst, input logic clr,
                      input logic [4:0] sel, input logic [1:0] trans,
                      input logic [31:0] addr, input logic wr,
                      input obs_t e, input bit full, input string nm);
    obs_t a, x;
    @(negedge h_clk);
    h_reset = rst; err_clr = clr; h_sel = sel;
    h_trans = trans; h_addr = addr; h_write = wr;
    exp_q.push_back(e);
    @(posedge h_clk);
    #1;
    a = actual(inst);
    x = exp_q.pop_front();
    chk({nm, ".ready"}, 32'(a.rdy), 32'(x.rdy));
    chk({nm, ".resp"}, 32'(a.resp), 32'(x.resp));
    if (full) begin
      chk({nm, ".valid"}, 32'(a.valid), 32'(x.valid));
      chk({nm, ".count"}, 32'(a.count), 32'(x.count));
      chk({nm, ".addr"}, a.addr, x.addr);
      chk({nm, ".write"}, 32'(a.wr), 32'(x.wr));
    end
  endtask

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] BSY = 2'b01;
  localparam logic [1:0] NSQ = 2'b10;
  localparam logic [1:0] SEQ = 2'b11;

  initial begin
    // instance u0, zero wait states, 8-bit counter
    vt.push_back(mkv(1, 0, 5'h00, IDL, 32'h0, 0, mk(1, 0, 0, 0, 32'h0, 0)));
    vt.push_back(mkv(0, 0, 5'h00, IDL, 32'h0, 0, mk(1, 0, 0, 0, 32'h0, 0)));
    vt.push_back(mkv(0, 0, 5'h01, NSQ, 32'h1234, 1, mk(1, 0, 0, 0, 32'h0, 0)));
    vt.push_back(mkv(0, 0, 5'h00, BSY, 32'h5678, 1, mk(1, 0, 0, 0, 32'h0, 0)));
    vt.push_back(mkv(0, 0, 5'h00, NSQ, 32'h4000_0000, 1,
                     mk(0, 1, 1, 1, 32'h4000_0000, 1)));
    vt.push_back(mkv(0, 0, 5'h00, IDL, 32'h0, 0,
                     mk(1, 1, 1, 1, 32'h4000_0000, 1)));
    vt.push_back(mkv(0, 0, 5'h00, IDL, 32'h0, 0,
                     mk(1, 0, 1, 1, 32'h4000_0000, 1)));
    vt.push_back(mkv(0, 0, 5'h00, NSQ, 32'h100, 0, mk(0, 1, 1, 2, 32'h100, 0)));
    vt.push_back(mkv(0, 0, 5'h00, NSQ, 32'h20, 1, mk(1, 1, 1, 2, 32'h100, 0)));
    vt.push_back(mkv(0, 0, 5'h00, NSQ, 32'h20, 0, mk(0, 1, 1, 3, 32'h20, 0)));
    vt.push_back(mkv(0, 0, 5'h00, IDL, 32'h0, 0, mk(1, 1, 1, 3, 32'h20, 0)));
    vt.push_back(mkv(0, 0, 5'h00, IDL, 32'h0, 0, mk(1, 0, 1, 3, 32'h20, 0)));
    vt.push_back(mkv(0, 1, 5'h00, SEQ, 32'h44, 1, mk(0, 1, 1, 1, 32'h44, 1)));
    vt.push_back(mkv(1, 0, 5'h00, IDL, 32'h0, 0, mk(1, 0, 0, 0, 32'h0, 0)));
    vt.push_back(mkv(0, 0, 5'h00, NSQ, 32'h8, 1, mk(0, 1, 1, 1, 32'h8, 1)));
    vt.push_back(mkv(1, 0, 5'h00, NSQ, 32'hC, 1, mk(1, 0, 0, 0, 32'h0, 0)));

    foreach (vt[i])
      step(0, vt[i].rst, vt[i].clr, vt[i].sel, vt[i].trans, vt[i].addr,
           vt[i].wr, vt[i].exp, 1, $sformatf("vec%0d", i));

    // u3: three wait states, single SEQ read
    step(1, 1, 0, 0, IDL, 0, 0, mk(1, 0, 0, 0, 0, 0), 1, "ws_rst");
    step(1, 0, 0, 0, SEQ, 32'h10, 0, mk(0, 0, 1, 1, 32'h10, 0), 1, "ws_w1");
    step(1, 0, 0, 0, IDL, 0, 0, mk(0, 0, 0, 0, 0, 0), 0, "ws_w2");
    step(1, 0, 0, 0, IDL, 0, 0, mk(0, 0, 0, 0, 0, 0), 0, "ws_w3");
    step(1, 0, 0, 0, IDL, 0, 0, mk(0, 1, 0, 0, 0, 0), 0, "ws_e1");
    step(1, 0, 0, 0, IDL, 0, 0, mk(1, 1, 0, 0, 0, 0), 0, "ws_e2");
    step(1, 0, 0, 0, IDL, 0, 0, mk(1, 0, 1, 1, 32'h10, 0), 1, "ws_idle");
    // back-to-back from ERR2 into WAIT, then reset while waiting
    step(1, 0, 0, 0, NSQ, 32'h30, 1, mk(0, 0, 1, 2, 32'h30, 1), 1, "b2b_w1");
    step(1, 0, 0, 0, IDL, 0, 0, mk(0, 0, 0, 0, 0, 0), 0, "b2b_w2");
    step(1, 0, 0, 0, IDL, 0, 0, mk(0, 0, 0, 0, 0, 0), 0, "b2b_w3");
    step(1, 0, 0, 0, IDL, 0, 0, mk(0, 1, 0, 0, 0, 0), 0, "b2b_e1");
    step(1, 0, 0, 0, IDL, 0, 0, mk(1, 1, 0, 0, 0, 0), 0, "b2b_e2");
    step(1, 0, 0, 0, NSQ, 32'h34, 0, mk(0, 0, 1, 3, 32'h34, 0), 1, "b2b_w");
    step(1, 1, 0, 0, IDL, 0, 0, mk(1, 0, 0, 0, 0, 0), 1, "wait_rst");

    // uc: 2-bit counter saturation and clear
    step(2, 1, 0, 0, IDL, 0, 0, mk(1, 0, 0, 0, 0, 0), 1, "sat_rst");
    for (int i = 0; i < 5; i++) begin
      step(2, 0, 0, 0, NSQ, 32'h100 + 32'(i), 1'(i),
           mk(0, 1, 1, 8'((i < 3) ? i + 1 : 3), 32'h100 + 32'(i), 1'(i)),
           1, $sformatf("sat%0d", i));
      step(2, 0, 0, 0, IDL, 0, 0, mk(1, 1, 0, 0, 0, 0), 0, "sat_e2");
      step(2, 0, 0, 0, IDL, 0, 0, mk(1, 0, 0, 0, 0, 0), 0, "sat_idle");
    end
    step(2, 0, 1, 0, IDL, 0, 0, mk(1, 0, 0, 0, 32'h104, 0), 1, "clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_default_slave_p.md
# ahb_default_slave_p

Parametrised AHB-Lite default slave for the interconnect. It responds to every transfer that no decoded slave claims (all `h_sel` bits low) with the two-cycle AHB ERROR response, after a configurable number of wait states. It also keeps an error log (last faulting address and direction, sticky valid flag, saturating count) for debug and interrupt logic. It sits beside the address decoder and drives the default input of the read-data/response mux.

## Interface

- `NUM_SLAVES`, 5, width of `h_sel`; the default slave is selected when every bit is 0.
- `ADDR_W`, 32, address width.
- `WAIT_STATES`, 0, OKAY-response wait cycles inserted before the ERROR response; legal range 0..15.
- `CNT_W`, 8, error counter width.

- `h_clk`  in  1  single clock; all logic on the rising edge.
- `h_reset`  in  1  synchronous, active-high reset.
- `h_sel`  in  NUM_SLAVES  decoder selects; one-hot or all-zero.
- `h_trans`  in  2  transfer type: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
- `h_addr`  in  ADDR_W  address-phase address.
- `h_write`  in  1  address-phase direction.
- `h_ready`  in  1  bus HREADY from the mux.
- `h_ready_out`  out  1  this slave's HREADYOUT.
- `h_resp`  out  1  this slave's HRESP: 0 OKAY, 1 ERROR.
- `err_clr`  in  1  synchronous clear of `err_valid` and `err_count`.
- `err_valid`  out  1  sticky flag: at least one error accepted since reset or clear.
- `err_addr`  out  ADDR_W  address of the most recent accepted error transfer.
- `err_write`  out  1  `h_write` of the most recent accepted error transfer.
- `err_count`  out  CNT_W  number of accepted error transfers; saturates at all-ones.

## Operation

- Accept condition (`acc`): `h_ready` = 1, `h_sel` = 0, and `h_trans` ∈ {NONSEQ, SEQ}.
- When `h_sel` = 0 and `h_trans` is IDLE or BUSY, the slave gives a zero-wait OKAY response: `h_ready_out` = 1, `h_resp` = 0.
- FSM states, with outputs registered and decoded from state only:
  - IDLE: `h_ready_out` = 1, `h_resp` = 0. If `acc`, go to WAIT when WAIT_STATES > 0, otherwise go to ERR1.
  - WAIT: `h_ready_out` = 0, `h_resp` = 0.
    - A down-counter is loaded with WAIT_STATES−1 on entry.
    - Go to ERR1 when the counter is 0; otherwise decrement.
    - Inputs are ignored.
  - ERR1: `h_ready_out` = 0, `h_resp` = 1. Always go to ERR2. Inputs are ignored.
  - ERR2: `h_ready_out` = 1, `h_resp` = 1.
    - If `acc`, go to WAIT or ERR1 by the same rule as IDLE (back-to-back error).
    - Otherwise go to IDLE.
- Error log, updated on every `acc` cycle:
  - `err_addr` ← `h_addr`, `err_write` ← `h_write`.
  - `err_valid` ← 1.
  - `err_count` ← `err_count` + 1, holding at 2^CNT_W−1.
- `err_clr` without `acc`: `err_valid` ← 0, `err_count` ← 0. `err_addr` and `err_write` hold their values.
- `err_clr` with `acc` in the same cycle: the accept wins. `err_valid` = 1, `err_count` = 1, and the address is captured.
- `h_sel` ≠ 0 with no transfer in progress: the slave stays in IDLE, outputs remain OKAY/ready, and the log is unchanged.

## Timing

- Reset (`h_reset` = 1 at an edge) gives:
  - state IDLE, `h_ready_out` = 1, `h_resp` = 0;
  - `err_valid` = 0, `err_count` = 0, `err_addr` = 0, `err_write` = 0;
  - wait counter = 0.
- Reset overrides every in-flight state, including WAIT, ERR1 and ERR2, and takes effect on the next edge.
- Address phase accepted at edge E gives:
  - cycles E+1 .. E+WAIT_STATES: WAIT (ready 0, resp 0);
  - next cycle: ERR1 (ready 0, resp 1);
  - following cycle: ERR2 (ready 1, resp 1).
- ERROR response length is exactly 2 cycles. Total data-phase length is WAIT_STATES+2.
- The error log is visible from the cycle after the accept edge, i.e. before the ERROR response starts.
- In ERR2, a master that cancels its pipelined transfer drives IDLE, and the slave returns to IDLE.

## Test plan

- Reset, then idle bus with `h_sel` = 0 and `h_trans` = IDLE → `h_ready_out` = 1, `h_resp` = 0, `err_valid` = 0 on every cycle.
- WAIT_STATES = 0: single NONSEQ to 0x4000_0000 with `h_write` = 1, unselected →
  - next cycle: ready 0, resp 1;
  - then: ready 1, resp 1;
  - then: ready 1, resp 0;
  - `err_addr` = 0x4000_0000, `err_write` = 1, `err_count` = 1.
- WAIT_STATES = 3: single SEQ read to 0x10 → 3 cycles of ready 0/resp 0, then 0/1, then 1/1; `err_write` = 0.
- Back-to-back errors: a new NONSEQ to 0x20 accepted during ERR2 → ERR1 on the next cycle with no IDLE gap. Expect `err_count` = 2 and `err_addr` = 0x20.
- CNT_W = 2: five error transfers → `err_count` = 3 (saturated). Then `err_clr` pulse → `err_count` = 0 and `err_valid` = 0, while `err_addr` holds its last value.
- Assert `h_reset` in ERR1 → next cycle ready 1, resp 0, and all log outputs = 0. Repeat with `err_clr` and `acc` in the same cycle → `err_count` = 1 and `err_valid` = 1.
